gshare_btb_predictor: RTL and testbench

- Parametrised successor to the single-cycle gshare path in the core Controller.
- Combines:
  - a 2-bit saturating-counter pattern history table (PHT), indexed by PC XOR global history;
  - a tagged branch target buffer (BTB) that supplies the predicted next PC;
  - a speculative global history register (GHR) with mispredict recovery.
- Sits in IF, is looked up with the fetch PC, and is trained from EX/MEM resolution.
- After reset, a self-initialisation FSM clears the tables.

---
 rtl/gshare_btb_predictor.sv | 134 +++++++++++++
 tb/tb_gshare_btb_predictor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: gshare PHT + tagged BTB + speculative GHR with recovery; `define BP_STATS_EN adds update/mispredict counters
module gshare_btb_predictor #(
  parameter int PC_W      = 32,
  parameter int IDX_W     = 8,
  parameter int GHR_W     = 8,
  parameter int BTB_IDX_W = 6,
  parameter int TAG_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             fetch_valid,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_is_cond,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);
  localparam int PTR_W = (IDX_W > BTB_IDX_W) ? IDX_W : BTB_IDX_W;
  localparam int PHT_N = 1 << IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;

  typedef enum logic {INIT, RUN} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic               ready_q;
  logic [GHR_W-1:0]   ghr_q, ghr_d;
  logic [1:0]         pht_q [PHT_N];
  logic [BTB_N-1:0]   valid_q, uncond_q;
  logic [TAG_W-1:0]   tag_q [BTB_N];
  logic [PC_W-1:0]    target_q [BTB_N];

  logic [IDX_W-1:0]     f_pidx, u_pidx;
  logic [BTB_IDX_W-1:0] f_bidx, u_bidx;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic [1:0]           ctr, cnt_d;
  logic                 upd_on, pht_we, btb_we, recover, spec_shift;

  assign f_pidx = fetch_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign f_bidx = fetch_pc[BTB_IDX_W+1:2];
  assign f_tag  = fetch_pc[TAG_W+BTB_IDX_W+1:BTB_IDX_W+2];
  assign u_pidx = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
  assign u_bidx = upd_pc[BTB_IDX_W+1:2];
  assign u_tag  = upd_pc[TAG_W+BTB_IDX_W+1:BTB_IDX_W+2];

  assign ready       = ready_q;
  assign pred_hit    = ready_q & valid_q[f_bidx] & (tag_q[f_bidx] == f_tag);
  assign pred_taken  = pred_hit & (uncond_q[f_bidx] | pht_q[f_pidx][1]);
  assign pred_target = pred_hit ? target_q[f_bidx] : '0;
  assign pred_ghr    = ghr_q;

  assign upd_on     = ready_q & upd_valid;
  assign pht_we     = upd_on & upd_is_cond;
  assign btb_we     = upd_on & upd_taken;
  assign recover    = upd_on & upd_mispredict;
  assign spec_shift = ready_q & fetch_valid & pred_hit & ~uncond_q[f_bidx];
  assign ctr        = pht_q[u_pidx];

  // Saturating counter step and GHR next state (recovery beats speculation)
  always_comb begin
    cnt_d = upd_taken ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                      : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
    ghr_d = recover    ? (upd_is_cond ? ((upd_ghr << 1) | GHR_W'(upd_taken)) : upd_ghr) :
            spec_shift ? ((ghr_q << 1) | GHR_W'(pred_taken)) : ghr_q;
  end

  // Init sweep FSM: one table entry cleared per cycle, ready raised on entering RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == INIT) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (ptr_q == '1) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // Global history register; held at zero through INIT because ready_q gates both sources
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  // Table storage: cleared by the sweep, trained from resolution once running
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      pht_q[ptr_q[IDX_W-1:0]]       <= 2'b01;
      valid_q[ptr_q[BTB_IDX_W-1:0]] <= 1'b0;
    end else begin
      if (pht_we) pht_q[u_pidx] <= cnt_d;
      if (btb_we) begin
        valid_q[u_bidx]  <= 1'b1;
        uncond_q[u_bidx] <= ~upd_is_cond;
        tag_q[u_bidx]    <= u_tag;
        target_q[u_bidx] <= upd_target;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

  // Saturating resolution counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (upd_on) begin
      if (stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
      if (upd_mispredict && stat_mp_q != '1) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// tb_gshare_btb_predictor: scoreboarded directed bench for gshare_btb_predictor
module tb_gshare_btb_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_ghr;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [7:0]  upd_ghr = '0;
  logic        upd_is_cond = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  typedef struct packed {
    logic        rdy;
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
    logic [7:0]  ghr;
  } obs_t;

  obs_t exp_q[$];
  obs_t e, o;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  gshare_btb_predictor dut (
    .clk(clk), .rst(rst), .ready(ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_is_cond(upd_is_cond),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic obs_t sample();
    return {ready, pred_hit, pred_taken, pred_target, pred_ghr};
  endfunction

  task automatic do_upd(input logic [31:0] pc, input logic [7:0] g, input logic cond,
                        input logic tk, input logic [31:0] tgt, input logic mp);
    @(negedge clk);
    upd_pc = pc; upd_ghr = g; upd_is_cond = cond; upd_taken = tk;
    upd_target = tgt; upd_mispredict = mp; upd_valid = 1'b1;
    exp_br++;
    if (mp) exp_mp++;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h40;
    @(negedge clk);
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 8'h0});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL reset_hold: got %h required %h", o, e); end
    @(posedge clk); #1 rst = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      @(negedge clk);
      exp_q.push_back('{k == 256, 1'b0, 1'b0, 32'h0, 8'h0});
      #1; e = exp_q.pop_front(); o = sample(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL init_cycle_%0d: got %h required %h", k, o, e); end
    end
    fetch_valid = 1'b0;
  endtask

  task automatic test_pht_train;
    logic [7:0] want_tk [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic       dir     [7] = '{1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      do_upd(32'h40, 8'h00, 1'b1, dir[i], 32'h80, 1'b0);
      fetch_pc = 32'h40;
      exp_q.push_back('{1'b1, 1'b1, want_tk[i][0], 32'h80, 8'h0});
      #1; e = exp_q.pop_front(); o = sample(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL pht_step_%0d: got %h required %h", i, o, e); end
    end
  endtask

  task automatic test_ghr_recovery;
    do_upd(32'h40, 8'h00, 1'b1, 1'b1, 32'h80, 1'b0);
    fetch_pc = 32'h40; fetch_valid = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 1'b1, 32'h80, 8'h00});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL ghr_pre_shift: got %h required %h", o, e); end
    @(negedge clk);
    upd_pc = 32'h40; upd_ghr = 8'hA5; upd_is_cond = 1'b1; upd_taken = 1'b0;
    upd_target = 32'h44; upd_mispredict = 1'b1; upd_valid = 1'b1;
    exp_br++; exp_mp++;
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'h80, 8'h01});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL ghr_spec_shift: got %h required %h", o, e); end
    @(negedge clk);
    upd_valid = 1'b0; fetch_valid = 1'b0;
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'h80, 8'h4A});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL ghr_recovery: got %h required %h", o, e); end
  endtask

  task automatic test_uncond;
    do_upd(32'h100, 8'h00, 1'b0, 1'b1, 32'h200, 1'b1);
    fetch_pc = 32'h100;
    exp_q.push_back('{1'b1, 1'b1, 1'b1, 32'h200, 8'h00});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL uncond_lookup: got %h required %h", o, e); end
    @(negedge clk);
    fetch_valid = 1'b1;
    @(negedge clk);
    fetch_valid = 1'b0;
    exp_q.push_back('{1'b1, 1'b1, 1'b1, 32'h200, 8'h00});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL uncond_no_shift: got %h required %h", o, e); end
    fetch_pc = 32'h40;
    exp_q.push_back('{1'b1, 1'b1, 1'b1, 32'h80, 8'h00});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL cond_after_restore: got %h required %h", o, e); end
  endtask

  task automatic test_miss_cases;
    do_upd(32'h180, 8'h00, 1'b1, 1'b0, 32'h300, 1'b0);
    fetch_pc = 32'h180;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 8'h00});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL not_taken_no_alloc: got %h required %h", o, e); end
    fetch_pc = 32'h4040;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 8'h00});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL tag_mismatch: got %h required %h", o, e); end
`ifdef BP_STATS_EN
    n_checks++;
    if (stat_branches !== 32'(exp_br) || stat_mispredicts !== 32'(exp_mp)) begin
      n_fail++;
      $display("FAIL stats_count: got %0d/%0d required %0d/%0d", stat_branches, stat_mispredicts, exp_br, exp_mp);
    end
`endif
  endtask

  task automatic test_reset_in_run;
    int cyc = 0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 8'h00});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL run_reset_immediate: got %h required %h", o, e); end
    @(negedge clk);
    rst = 1'b1;
    while (cyc < 400) begin
      @(negedge clk); #1; cyc++;
      if (ready) break;
    end
    n_checks++;
    if (cyc != 256) begin n_fail++; $display("FAIL reinit_length: got %0d cycles required 256", cyc); end
    fetch_pc = 32'h40;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 8'h00});
    #1; e = exp_q.pop_front(); o = sample(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL reinit_forgets: got %h required %h", o, e); end
`ifdef BP_STATS_EN
    n_checks++;
    if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d/%0d required 0/0", stat_branches, stat_mispredicts);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_pht_train;
    test_ghr_recovery;
    test_uncond;
    test_miss_cases;
    test_reset_in_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
